// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for the period meter and its input conditioner.
package clk_period_meter_pkg;

  localparam int COUNT_W_DEFAULT     = 32;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input plus a history flop that
// yields a single-cycle rising-edge pulse. Reusable for switch/button inputs.
module sync_edge_detect
  import clk_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  // Bit 0 is the metastability-exposed stage; the top bit is the clean level.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the edge-to-edge period of a slow asynchronous signal in clk_100mhz
// cycles and hands each result out over a valid/ready register.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int COUNT_W     = COUNT_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic               clk_100mhz,
  input  logic               rst_n,
  input  logic               sig_in,
  input  logic               enable,
  output logic [COUNT_W-1:0] period,
  output logic               period_valid,
  input  logic               period_ready,
  output logic               overrun,
  output logic               timeout,
  input  logic               clear_flags
);

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  logic sig_rise;
  logic sig_level_unused;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk_100mhz),
    .rst_n (rst_n),
    .din   (sig_in),
    .level (sig_level_unused),
    .rise  (sig_rise)
  );

  meter_state_t       state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] period_q, period_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  logic [COUNT_W-1:0] count_inc;
  logic               publish;
  logic               ovr_set;
  logic               to_set;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    valid_d   = valid_q;
    publish   = 1'b0;
    ovr_set   = 1'b0;
    to_set    = 1'b0;
    count_inc = count_q + CNT_ONE;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable) state_d = ARM;
      end
      ARM: begin
        if (!enable) begin
          state_d = IDLE;
          count_d = '0;
        end else if (sig_rise) begin
          state_d = MEASURE;
          count_d = CNT_ONE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
          count_d = '0;
        end else if (sig_rise) begin
          // Each edge closes one period and opens the next.
          publish = 1'b1;
          count_d = CNT_ONE;
        end else if (&count_inc) begin
          to_set  = 1'b1;
          count_d = '0;
          state_d = ARM;
        end else begin
          count_d = count_inc;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    // A result loads if the slot is free or being emptied this cycle.
    if (publish) begin
      if (!valid_q || period_ready) begin
        period_d = count_q;
        valid_d  = 1'b1;
      end else begin
        ovr_set  = 1'b1;
      end
    end else if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end

    overrun_d = ovr_set | (overrun_q & ~clear_flags);
    timeout_d = to_set  | (timeout_q & ~clear_flags);
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter with a timestamp-based reference model.
module tb_clk_period_meter;

  localparam int CW  = 8;
  localparam int SS  = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk_100mhz   = 1'b0;
  logic          rst_n        = 1'b0;
  logic          sig_in       = 1'b0;
  logic          enable       = 1'b0;
  logic          period_ready = 1'b0;
  logic          clear_flags  = 1'b0;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          overrun;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  clk_period_meter #(
    .COUNT_W     (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .rst_n        (rst_n),
    .sig_in       (sig_in),
    .enable       (enable),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .overrun      (overrun),
    .timeout      (timeout),
    .clear_flags  (clear_flags)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchronizer is a pure delay of SS samples, so an
  // edge is seen when the sample SS clocks ago is 1 and the one before is 0.
  // Periods are differences of edge timestamps.
  logic [SS+1:1] hist;
  int            cyc, start, elapsed;
  bit            armed, measuring, e, pub, ovr_set, to_set;
  logic [CW-1:0] m_period;
  bit            m_valid, m_ovr, m_to;

  initial forever begin
    @(posedge clk_100mhz or negedge rst_n);
    if (!rst_n) begin
      hist = '0; cyc = 0; start = 0; armed = 0; measuring = 0;
      m_period = '0; m_valid = 0; m_ovr = 0; m_to = 0;
    end else begin
      e = hist[SS] & ~hist[SS+1];
      pub = 0; ovr_set = 0; to_set = 0; elapsed = 0;
      if (!enable) begin
        armed = 0; measuring = 0;
      end else if (!armed && !measuring) begin
        armed = 1;
      end else if (armed) begin
        if (e) begin armed = 0; measuring = 1; start = cyc; end
      end else if (e) begin
        pub = 1; elapsed = cyc - start; start = cyc;
      end else if (cyc - start + 1 >= SAT) begin
        to_set = 1; measuring = 0; armed = 1;
      end
      if (pub) begin
        if (!m_valid || period_ready) begin m_period = CW'(elapsed); m_valid = 1; end
        else ovr_set = 1;
      end else if (m_valid && period_ready) begin
        m_valid = 0;
      end
      m_ovr = ovr_set | (m_ovr & !clear_flags);
      m_to  = to_set  | (m_to  & !clear_flags);
      hist  = {hist[SS:1], sig_in};
      cyc++;
    end
  end

  initial forever begin
    @(negedge clk_100mhz);
    if (rst_n) begin
      check("period",       32'(period),       32'(m_period));
      check("period_valid", 32'(period_valid), 32'(m_valid));
      check("overrun",      32'(overrun),      32'(m_ovr));
      check("timeout",      32'(timeout),      32'(m_to));
    end
  end

  // Waveform generator: period wper cycles, high for whi of them.
  int wper = 0, whi = 1, wph = 0;
  initial forever begin
    @(negedge clk_100mhz);
    if (wper == 0) sig_in = 1'b0;
    else begin
      sig_in = (wph < whi);
      wph    = (wph + 1 >= wper) ? 0 : wph + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk_100mhz); #1; end
  endtask

  task automatic set_wave(input int per, input int hi);
    wper = per; whi = hi; wph = 0;
  endtask

  initial begin
    bit found;
    int seg, per;

    step(3);
    check("rst_period",  32'(period),       0);
    check("rst_valid",   32'(period_valid), 0);
    check("rst_overrun", 32'(overrun),      0);
    check("rst_timeout", 32'(timeout),      0);
    rst_n = 1'b1;

    // Square wave of 10 cycles, consumer always ready.
    enable = 1'b1; period_ready = 1'b1;
    set_wave(10, 5);
    step(100);
    check("lit_period10", 32'(period), 10);

    // Period 20 with a stalled consumer: first result held, later ones dropped.
    enable = 1'b0; step(3);
    period_ready = 1'b0; set_wave(20, 10); enable = 1'b1;
    step(100);
    check("lit_period20", 32'(period),       20);
    check("lit_valid20",  32'(period_valid), 1);
    check("lit_overrun",  32'(overrun),      1);
    period_ready = 1'b1; step(1); period_ready = 1'b0; step(2);
    clear_flags = 1'b1; step(1); clear_flags = 1'b0;
    check("lit_ovr_clr", 32'(overrun), 0);

    // Enable dropped part-way through a 50-cycle period.
    period_ready = 1'b1; enable = 1'b0; step(2);
    set_wave(50, 25); enable = 1'b1;
    step(60);
    enable = 1'b0; step(3); enable = 1'b1;
    step(130);
    check("lit_period50", 32'(period), 50);

    // 1-cycle pulse every 300 cycles saturates the 8-bit counter.
    enable = 1'b0; step(2);
    set_wave(300, 1); enable = 1'b1;
    step(700);
    check("lit_timeout", 32'(timeout),      1);
    check("lit_no_valid", 32'(period_valid), 0);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1);
      if (sig_in) found = 1;
    end
    check("wait_rise", 32'(found), 1);
    clear_flags = 1'b1; step(1); clear_flags = 1'b0;
    step(10);
    check("lit_to_clr", 32'(timeout), 0);
    step(300);
    check("lit_to_again", 32'(timeout), 1);

    // Asynchronous reset in the middle of a measurement with a pending result.
    enable = 1'b0; step(2);
    period_ready = 1'b0; set_wave(30, 15); enable = 1'b1;
    step(100);
    check("pre_rst_valid", 32'(period_valid), 1);
    @(negedge clk_100mhz); #2;
    rst_n = 1'b0; #1;
    check("arst_period",  32'(period),       0);
    check("arst_valid",   32'(period_valid), 0);
    check("arst_overrun", 32'(overrun),      0);
    check("arst_timeout", 32'(timeout),      0);
    step(3);
    rst_n = 1'b1; period_ready = 1'b1;
    step(100);
    check("lit_period30", 32'(period), 30);

    // Random segments: waveform, consumer stalls, enable glitches, flag clears.
    for (int s = 0; s < 12; s++) begin
      per = $urandom_range(2, 300);
      set_wave(per, $urandom_range(1, per - 1));
      seg = $urandom_range(150, 600);
      for (int c = 0; c < seg; c++) begin
        period_ready = ($urandom_range(0, 3) != 0);
        clear_flags  = ($urandom_range(0, 63) == 0);
        enable       = ($urandom_range(0, 299) != 0);
        step(1);
      end
    end
    enable = 1'b1; clear_flags = 1'b0;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
